add_serial_ctrl: RTL and testbench

Nibble-serial add sequencer that computes WIDTH-bit sums by driving one external 4-bit ripple adder (`add_4b`: x, y, out, Cin, Cout) once per clock. It latches two operands on a start request and feeds the adder one nibble per cycle, least-significant first, chaining the carry through a register. It then presents the full sum and carry-out with a one-cycle done pulse. It sits between a requesting sequencer or ALU control and the shared 4-bit adder, so wide adds reuse the same adder hardware.

---
 rtl/add_serial_ctrl.sv | 112 +++++++++++
 tb/tb_add_serial_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/add_serial_ctrl.sv
// Nibble-serial add sequencer: computes WIDTH-bit a+b+cin by driving a shared
// external 4-bit adder one nibble per clock, least-significant nibble first,
// with the carry chained through a register between nibbles.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; adder inputs held at 0; sum/cout hold last result
// RUN   | one nibble on the adder per cycle; result shifted into sum
// DONE  | one-cycle done pulse with sum/cout valid; start is ignored here
module add_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_x,
    output logic [3:0]       add_y,
    output logic             add_cin,
    input  logic [3:0]       add_out,
    input  logic             add_cout
);

    localparam int NIBBLES = WIDTH / 4;
    // Keep the counter at least one bit wide so WIDTH=4 still elaborates.
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    // Sequencer: operand latch, per-nibble capture and result shift, done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // Shift-in from the top: after NIBBLES captures the first
                    // nibble has walked down to sum[3:0].
                    sum     <= (sum >> 4) | (WIDTH'(add_out) << (WIDTH - 4));
                    carry_q <= add_cout;
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout  <= add_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Adder drive: current low nibbles and chained carry while running, else 0.
    always_comb begin
        add_x   = 4'h0;
        add_y   = 4'h0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_x   = a_sh[3:0];
            add_y   = b_sh[3:0];
            add_cin = carry_q;
        end
    end

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Directed bench for add_serial_ctrl (WIDTH=16) with a behavioural 4-bit
// adder closing the loop on add_x/add_y/add_cin -> add_out/add_cout.
module tb_add_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  add_x;
    logic [3:0]  add_y;
    logic        add_cin;
    logic [3:0]  add_out;
    logic        add_cout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // 4-bit ripple adder stand-in (purely combinational)
    assign {add_cout, add_out} = 5'({1'b0, add_x}) + 5'({1'b0, add_y}) + 5'(add_cin);

    add_serial_ctrl #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .add_x    (add_x),
        .add_y    (add_y),
        .add_cin  (add_cin),
        .add_out  (add_out),
        .add_cout (add_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Called in the cycle after the accepting edge; waits (bounded) for done,
    // checks latency, busy length and the result.
    task automatic wait_done(input string tag, input logic [15:0] exp_sum, input logic exp_cout);
        int k = 0;
        int busy_cnt = 0;
        while (done !== 1'b1 && k < 20) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'd4);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_out [4];
        logic [3:0] exp_x   [4];
        logic [3:0] exp_y   [4];
        int done_seen;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_sum",     32'(sum),     32'h0);
        chk("rst_cout",    32'(cout),    32'd0);
        chk("rst_add_x",   32'(add_x),   32'd0);
        chk("rst_add_y",   32'(add_y),   32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);

        // start together with reset: reset wins
        start = 1'b1; a = 16'h1234; b = 16'h4321;
        tick();
        chk("rst_wins_busy", 32'(busy), 32'd0);
        start = 1'b0; rst_n = 1'b1;
        tick();

        // basic add 0x1234 + 0x4321
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy_first", 32'(busy),  32'd1);
        chk("t1_add_x0",     32'(add_x), 32'h4);
        chk("t1_add_y0",     32'(add_y), 32'h1);
        wait_done("t1", 16'h5555, 1'b0);

        // 0xFFFF + 0 + 1: carry propagates every nibble
        tick();
        a = 16'hFFFF; b = 16'h0000; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_add_cin%0d", i), 32'(add_cin), 32'd1);
            chk($sformatf("t2_busy%0d", i),    32'(busy),    32'd1);
            tick();
        end
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_sum",  32'(sum),  32'h0000);
        chk("t2_cout", 32'(cout), 32'd1);
        tick();

        // 0x8D8D + 0x9696: nibble outs 3,2,4,2 each with carry out 1
        exp_x[0] = 4'hD; exp_x[1] = 4'h8; exp_x[2] = 4'hD; exp_x[3] = 4'h8;
        exp_y[0] = 4'h6; exp_y[1] = 4'h9; exp_y[2] = 4'h6; exp_y[3] = 4'h9;
        exp_out[0] = 4'h3; exp_out[1] = 4'h2; exp_out[2] = 4'h4; exp_out[3] = 4'h2;
        a = 16'h8D8D; b = 16'h9696; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_add_x%0d", i),   32'(add_x),    32'(exp_x[i]));
            chk($sformatf("t3_add_y%0d", i),   32'(add_y),    32'(exp_y[i]));
            chk($sformatf("t3_add_cin%0d", i), 32'(add_cin),  (i == 0) ? 32'd0 : 32'd1);
            chk($sformatf("t3_out%0d", i),     32'(add_out),  32'(exp_out[i]));
            chk($sformatf("t3_cout%0d", i),    32'(add_cout), 32'd1);
            tick();
        end
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_sum",  32'(sum),  32'h2423);
        chk("t3_cout", 32'(cout), 32'd1);
        tick();

        // start held high; operands change mid-RUN
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        tick();                                   // k=0
        tick();                                   // k=1
        a = 16'hAAAA; b = 16'h5555;
        tick(); tick(); tick();                   // k=4
        chk("t4_done1", 32'(done), 32'd1);
        chk("t4_sum1",  32'(sum),  32'h5555);
        chk("t4_cout1", 32'(cout), 32'd0);
        tick();                                   // k=5 IDLE
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_done", 32'(done), 32'd0);
        tick();                                   // k=6 second RUN
        start = 1'b0;
        chk("t4_busy2",  32'(busy),  32'd1);
        chk("t4_add_x2", 32'(add_x), 32'hA);
        chk("t4_add_y2", 32'(add_y), 32'h5);
        wait_done("t4b", 16'hFFFF, 1'b0);

        // reset mid-RUN aborts without a done pulse
        tick();
        a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
        tick();                                   // k=0
        start = 1'b0;
        tick();                                   // k=1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy",    32'(busy),    32'd0);
        chk("t5_done",    32'(done),    32'd0);
        chk("t5_sum",     32'(sum),     32'h0);
        chk("t5_cout",    32'(cout),    32'd0);
        chk("t5_add_x",   32'(add_x),   32'd0);
        chk("t5_add_y",   32'(add_y),   32'd0);
        chk("t5_add_cin", 32'(add_cin), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        chk("t5_no_done", 32'(done_seen), 32'd0);
        a = 16'h0001; b = 16'h0001; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t5b", 16'h0003, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
